lmsm_seq: RTL and testbench

Load-multiple / store-multiple micro-op sequencer for the 8-register RISC pipeline. Sits between decode and execute. It expands one LM or SM instruction, with an 8-bit register mask, into one single-register memory micro-op per set mask bit. These micro-ops produce the per-cycle LM/SM flags and register addresses that the downstream load/store forwarding detector consumes. While expanding, it asserts `seq_busy` so fetch/decode hold.

---
 rtl/lmsm_pkg.sv | 16 +
 rtl/lsb_pri_enc.sv | 41 ++++
 rtl/lmsm_seq.sv | 117 +++++++++++
 tb/tb_lmsm_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// Shared types and constants for the LM/SM micro-op sequencer.
package lmsm_pkg;

    localparam int REG_W  = 3;
    localparam int MASK_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic uop_type_t;
    localparam uop_type_t UOP_LM = 1'b0;
    localparam uop_type_t UOP_SM = 1'b1;

endpackage

// File: rtl/lsb_pri_enc.sv
// Lowest-set-bit encoder: index of the first set mask bit, the mask with
// that bit removed, and whether anything remains after removing it.
module lsb_pri_enc #(
    parameter int MASK_W = 8,
    parameter int REG_W  = 3
) (
    input  logic [MASK_W-1:0] mask,
    output logic [REG_W-1:0]  idx,
    output logic              found,
    output logic [MASK_W-1:0] rest,
    output logic              rest_zero
);

    // lower_any[i] is set when any bit below position i is set
    logic [MASK_W-1:0] lower_any;
    logic [MASK_W-1:0] first;

    assign lower_any[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < MASK_W; gi++) begin : g_prefix
            assign lower_any[gi] = lower_any[gi-1] | mask[gi-1];
        end
    endgenerate

    assign first     = mask & ~lower_any;
    assign found     = |mask;
    assign rest      = mask & ~first;
    assign rest_zero = (rest == '0);

    // first is one-hot (or zero), so OR-ing the indices yields the position
    always_comb begin
        idx = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (first[i]) begin
                idx = idx | REG_W'(i);
            end
        end
    end

endmodule

// File: rtl/lmsm_seq.sv
// LM/SM expander: turns one multi-register instruction into a stream of
// single-register memory micro-ops, lowest register first.
module lmsm_seq
    import lmsm_pkg::*;
#(
    parameter int REG_W  = lmsm_pkg::REG_W,
    parameter int MASK_W = lmsm_pkg::MASK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_is_lm,
    input  logic              id_is_sm,
    input  logic [REG_W-1:0]  id_ra,
    input  logic [MASK_W-1:0] id_mask,
    input  logic              stall_in,
    input  logic              flush,
    output logic              seq_busy,
    output logic              uop_valid,
    output logic              uop_lm,
    output logic              uop_sm,
    output logic [REG_W-1:0]  uop_rd,
    output logic [REG_W-1:0]  uop_ra,
    output logic [2:0]        uop_offset,
    output logic              uop_last
);

    state_t            state_reg;
    logic [MASK_W-1:0] mask_reg;
    logic [REG_W-1:0]  ra_reg;
    uop_type_t         type_reg;
    logic [2:0]        cnt_reg;

    logic [REG_W-1:0]  enc_idx;
    logic              enc_found;
    logic [MASK_W-1:0] enc_rest;
    logic              enc_rest_zero;

    lsb_pri_enc #(
        .MASK_W (MASK_W),
        .REG_W  (REG_W)
    ) u_enc (
        .mask      (mask_reg),
        .idx       (enc_idx),
        .found     (enc_found),
        .rest      (enc_rest),
        .rest_zero (enc_rest_zero)
    );

    assign seq_busy = (state_reg == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mask_reg   <= '0;
            ra_reg     <= '0;
            type_reg   <= UOP_LM;
            cnt_reg    <= '0;
            uop_valid  <= 1'b0;
            uop_lm     <= 1'b0;
            uop_sm     <= 1'b0;
            uop_rd     <= '0;
            uop_ra     <= '0;
            uop_offset <= '0;
            uop_last   <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            uop_valid <= 1'b0;
            uop_lm    <= 1'b0;
            uop_sm    <= 1'b0;
            uop_last  <= 1'b0;
        end else if (!stall_in) begin
            case (state_reg)
                IDLE: begin
                    uop_valid <= 1'b0;
                    uop_lm    <= 1'b0;
                    uop_sm    <= 1'b0;
                    uop_last  <= 1'b0;
                    if (id_valid && (id_is_lm || id_is_sm)) begin
                        mask_reg <= id_mask;
                        ra_reg   <= id_ra;
                        type_reg <= id_is_lm ? UOP_LM : UOP_SM;
                        cnt_reg  <= '0;
                        // An empty register list retires as a NOP
                        if (id_mask != '0) begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (enc_found) begin
                        uop_valid  <= 1'b1;
                        uop_lm     <= (type_reg == UOP_LM);
                        uop_sm     <= (type_reg == UOP_SM);
                        uop_ra     <= ra_reg;
                        uop_rd     <= enc_idx;
                        uop_offset <= cnt_reg;
                        uop_last   <= enc_rest_zero;
                        mask_reg   <= enc_rest;
                        cnt_reg    <= cnt_reg + 3'd1;
                        if (enc_rest_zero) begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        // Unreachable with a consistent mask; recover quietly
                        uop_valid <= 1'b0;
                        uop_last  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_seq.sv
// Directed scoreboard bench for lmsm_seq: stimulus pushes expected micro-ops,
// a negedge monitor pops and compares each freshly presented micro-op.
module tb_lmsm_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic       id_is_lm;
    logic       id_is_sm;
    logic [2:0] id_ra;
    logic [7:0] id_mask;
    logic       stall_in;
    logic       flush;
    logic       seq_busy;
    logic       uop_valid;
    logic       uop_lm;
    logic       uop_sm;
    logic [2:0] uop_rd;
    logic [2:0] uop_ra;
    logic [2:0] uop_offset;
    logic       uop_last;

    typedef struct packed {
        logic       lm;
        logic       sm;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] off;
        logic       last;
    } uop_t;

    uop_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   busy_total = 0;
    int   fresh_total = 0;
    logic stall_q = 1'b0;

    lmsm_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_is_lm   (id_is_lm),
        .id_is_sm   (id_is_sm),
        .id_ra      (id_ra),
        .id_mask    (id_mask),
        .stall_in   (stall_in),
        .flush      (flush),
        .seq_busy   (seq_busy),
        .uop_valid  (uop_valid),
        .uop_lm     (uop_lm),
        .uop_sm     (uop_sm),
        .uop_rd     (uop_rd),
        .uop_ra     (uop_ra),
        .uop_offset (uop_offset),
        .uop_last   (uop_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic ok, input string name, input int act, input int exp);
        checks++;
        if (ok) begin
            passed++;
            $display("check %-16s ok   act=0x%0h", name, act);
        end else begin
            $display("FAIL %-16s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic lm, input logic sm, input int rd, input int ra,
                        input int off, input logic last);
        uop_t u;
        u.lm   = lm;
        u.sm   = sm;
        u.rd   = 3'(rd);
        u.ra   = 3'(ra);
        u.off  = 3'(off);
        u.last = last;
        q.push_back(u);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic lm, input logic sm, input logic [2:0] ra,
                         input logic [7:0] mask);
        id_valid = 1'b1;
        id_is_lm = lm;
        id_is_sm = sm;
        id_ra    = ra;
        id_mask  = mask;
        tick();
        id_valid = 1'b0;
        id_is_lm = 1'b0;
        id_is_sm = 1'b0;
        id_mask  = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((q.size() != 0 || seq_busy) && n < 40) begin
            tick();
            n++;
        end
        chk(n < 40, name, n, 40);
    endtask

    // Pipeline-facing state sampled at the active edge
    always @(posedge clk) stall_q <= stall_in;

    always @(negedge clk) begin
        if (seq_busy) busy_total++;
        if (uop_valid && !stall_q) begin
            uop_t act;
            uop_t exp;
            fresh_total++;
            act = '{uop_lm, uop_sm, uop_rd, uop_ra, uop_offset, uop_last};
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_uop", int'(act), 0);
            end else begin
                exp = q.pop_front();
                chk(act == exp, "uop", int'(act), int'(exp));
            end
        end
    end

    initial begin
        int b0;
        int f0;
        rst_n    = 1'b0;
        id_valid = 1'b0;
        id_is_lm = 1'b0;
        id_is_sm = 1'b0;
        id_ra    = 3'd0;
        id_mask  = 8'h00;
        stall_in = 1'b0;
        flush    = 1'b0;
        repeat (3) tick();
        chk({seq_busy, uop_valid, uop_lm, uop_sm, uop_rd, uop_ra, uop_offset, uop_last} == 14'h0,
            "reset_outputs",
            int'({seq_busy, uop_valid, uop_lm, uop_sm, uop_rd, uop_ra, uop_offset, uop_last}), 0);
        rst_n = 1'b1;
        tick();

        // LM 0xA5 from r3: rd 0,2,5,7
        push(1, 0, 0, 3, 0, 0);
        push(1, 0, 2, 3, 1, 0);
        push(1, 0, 5, 3, 2, 0);
        push(1, 0, 7, 3, 3, 1);
        b0 = busy_total;
        issue(1, 0, 3'd3, 8'hA5);
        wait_done("lm_a5_done");
        chk(busy_total - b0 == 4, "lm_a5_busy", busy_total - b0, 4);
        chk(uop_valid == 1'b0, "lm_a5_idle", int'(uop_valid), 0);

        // Empty SM is a NOP, following LM accepted the next cycle
        b0 = busy_total;
        issue(0, 1, 3'd2, 8'h00);
        chk({seq_busy, uop_valid} == 2'b00, "sm_empty_nop", int'({seq_busy, uop_valid}), 0);
        push(1, 0, 0, 0, 0, 1);
        issue(1, 0, 3'd0, 8'h01);
        chk(seq_busy == 1'b1, "lm_01_busy_on", int'(seq_busy), 1);
        wait_done("lm_01_done");
        chk(busy_total - b0 == 1, "lm_01_busy", busy_total - b0, 1);
        tick();

        // SM 0x0F with a 2-cycle stall while rd=1 is presented
        push(0, 1, 0, 5, 0, 0);
        push(0, 1, 1, 5, 1, 0);
        push(0, 1, 2, 5, 2, 0);
        push(0, 1, 3, 5, 3, 1);
        b0 = busy_total;
        issue(0, 1, 3'd5, 8'h0F);
        tick();
        tick();
        stall_in = 1'b1;
        chk({uop_rd, uop_offset} == 6'o11, "stall_hold0", int'({uop_rd, uop_offset}), 6'o11);
        tick();
        chk({uop_rd, uop_offset} == 6'o11, "stall_hold1", int'({uop_rd, uop_offset}), 6'o11);
        tick();
        stall_in = 1'b0;
        chk({uop_rd, uop_offset} == 6'o11, "stall_hold2", int'({uop_rd, uop_offset}), 6'o11);
        wait_done("sm_0f_done");
        chk(busy_total - b0 == 6, "sm_0f_busy", busy_total - b0, 6);
        tick();

        // LM 0xFF flushed after the third micro-op, then SM 0x80
        push(1, 0, 0, 2, 0, 0);
        push(1, 0, 1, 2, 1, 0);
        push(1, 0, 2, 2, 2, 0);
        issue(1, 0, 3'd2, 8'hFF);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk({seq_busy, uop_valid} == 2'b00, "flush_clear", int'({seq_busy, uop_valid}), 0);
        push(0, 1, 7, 6, 0, 1);
        issue(0, 1, 3'd6, 8'h80);
        wait_done("post_flush_done");
        tick();

        // Reset in the middle of LM 0xF0 after two micro-ops
        push(1, 0, 4, 1, 0, 0);
        push(1, 0, 5, 1, 1, 0);
        f0 = fresh_total;
        issue(1, 0, 3'd1, 8'hF0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk({seq_busy, uop_valid, uop_lm, uop_sm, uop_rd, uop_ra, uop_offset, uop_last} == 14'h0,
            "midseq_reset",
            int'({seq_busy, uop_valid, uop_lm, uop_sm, uop_rd, uop_ra, uop_offset, uop_last}), 0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk(fresh_total - f0 == 2, "reset_no_residue", fresh_total - f0, 2);
        chk(q.size() == 0, "reset_queue", q.size(), 0);

        // LM and SM both set: LM wins
        push(1, 0, 0, 4, 0, 0);
        push(1, 0, 1, 4, 1, 1);
        b0 = busy_total;
        issue(1, 1, 3'd4, 8'h03);
        wait_done("both_done");
        chk(busy_total - b0 == 2, "both_busy", busy_total - b0, 2);
        repeat (3) tick();
        chk(q.size() == 0, "final_queue", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
